// File: rtl/fft_radix2_stream.sv
// rtl/fft_radix2_stream.sv - streaming radix-2 DIT FFT, bit-reversed load, one in-place butterfly per cycle
module fft_radix2_stream #(
    parameter int N     = 8,
    parameter int LOG2N = 3,
    parameter int DW    = 8,
    parameter int OW    = DW + LOG2N + 1,
    parameter int TW_W  = 16
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_re,
    output logic [OW-1:0] out_im,
    output logic          out_last,
    output logic          busy
);
    localparam int SW = $clog2(LOG2N);
    localparam int PW = OW + TW_W + 1;
    localparam logic signed [PW-1:0] RND = PW'(2 ** (TW_W - 2));
    localparam logic [LOG2N-2:0] BFLY_LAST  = '1;
    localparam logic [SW-1:0]    STAGE_LAST = SW'(LOG2N - 1);
    localparam logic [LOG2N-1:0] CNT_LAST   = '1;

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
    state_t state, state_next;

    logic signed [OW-1:0] mem_re [N];
    logic signed [OW-1:0] mem_im [N];
    logic [LOG2N-1:0] load_cnt, out_cnt;
    logic [SW-1:0]    stage;
    logic [LOG2N-2:0] bfly;
    logic             last_bfly, last_out;

    logic [LOG2N-1:0]       jx, low_mask, idx_a, idx_b;
    logic [2:0]             tw_idx;
    logic [31:0]            tw;
    logic signed [TW_W-1:0] w_c, w_s;
    logic signed [OW-1:0]   a_re, a_im, b_re, b_im, wb_re, wb_im, x_re, x_im, y_re, y_im;
    logic signed [PW-1:0]   p_re, p_im;
    logic                   unused_bits;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    // 16-point table {cos, sin} in Q1.15, index m = 2*pi*m/16; smaller N strides through it
    function automatic logic [31:0] tw_rom(input logic [2:0] m);
        case (m)
            3'd0:    tw_rom = {16'h7FFF, 16'h0000};
            3'd1:    tw_rom = {16'h7642, 16'h30FC};
            3'd2:    tw_rom = {16'h5A82, 16'h5A82};
            3'd3:    tw_rom = {16'h30FC, 16'h7642};
            3'd4:    tw_rom = {16'h0000, 16'h7FFF};
            3'd5:    tw_rom = {16'hCF04, 16'h7642};
            3'd6:    tw_rom = {16'hA57E, 16'h5A82};
            default: tw_rom = {16'h89BE, 16'h30FC};
        endcase
    endfunction

    assign last_bfly = (stage == STAGE_LAST) && (bfly == BFLY_LAST);
    assign last_out  = (out_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (clear) state <= LOAD;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && load_cnt == CNT_LAST) state_next = COMPUTE;
            end
            COMPUTE: if (last_bfly) state_next = UNLOAD;
            UNLOAD:  if (out_ready && last_out) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // Butterfly j of stage s: a keeps the low s bits of j and inserts a 0 at bit s, b sets that bit
    always_comb begin
        jx       = {1'b0, bfly};
        low_mask = LOG2N'((1 << stage) - 1);
        idx_a    = ((jx & ~low_mask) << 1) | (jx & low_mask);
        idx_b    = idx_a | LOG2N'(1 << stage);
        tw_idx   = 3'(4'(jx & low_mask) << (3 - stage));
        tw       = tw_rom(tw_idx);
        w_c      = tw[31 -: TW_W];
        w_s      = tw[15 -: TW_W];
        a_re     = mem_re[idx_a];
        a_im     = mem_im[idx_a];
        b_re     = mem_re[idx_b];
        b_im     = mem_im[idx_b];
        p_re     = PW'(b_re) * PW'(w_c) + PW'(b_im) * PW'(w_s) + RND;
        p_im     = PW'(b_im) * PW'(w_c) - PW'(b_re) * PW'(w_s) + RND;
        if (tw_idx == 3'd0) begin
            wb_re = b_re;
            wb_im = b_im;
        end else if (tw_idx == 3'd4) begin
            wb_re = b_im;
            wb_im = -b_re;
        end else begin
            wb_re = p_re[TW_W-1 +: OW];
            wb_im = p_im[TW_W-1 +: OW];
        end
        x_re = a_re + wb_re;
        x_im = a_im + wb_im;
        y_re = a_re - wb_re;
        y_im = a_im - wb_im;
    end

    assign unused_bits = ^{p_re[PW-1 -: 2], p_re[TW_W-2:0], p_im[PW-1 -: 2], p_im[TW_W-2:0]};

    always_ff @(posedge clk) begin
        if (clear) begin
            load_cnt  <= '0;
            out_cnt   <= '0;
            stage     <= '0;
            bfly      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            case (state)
                LOAD: if (in_valid) begin
                    mem_re[bitrev(load_cnt)] <= OW'($signed(in_re));
                    mem_im[bitrev(load_cnt)] <= OW'($signed(in_im));
                    load_cnt <= load_cnt + 1'b1;
                end
                COMPUTE: begin
                    mem_re[idx_a] <= x_re;
                    mem_im[idx_a] <= x_im;
                    mem_re[idx_b] <= y_re;
                    mem_im[idx_b] <= y_im;
                    bfly <= bfly + 1'b1;
                    if (bfly == BFLY_LAST) stage <= stage + 1'b1;
                    if (last_bfly) begin
                        // Bin 0 was finished by the first butterfly of the final stage
                        stage     <= '0;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        out_cnt   <= '0;
                        out_re    <= mem_re[0];
                        out_im    <= mem_im[0];
                    end
                end
                UNLOAD: if (out_ready) begin
                    if (last_out) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_cnt   <= '0;
                    end else begin
                        out_cnt  <= out_cnt + 1'b1;
                        out_re   <= mem_re[out_cnt + 1'b1];
                        out_im   <= mem_im[out_cnt + 1'b1];
                        out_last <= ((out_cnt + 1'b1) == CNT_LAST);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_radix2_stream.sv
// tb/tb_fft_radix2_stream.sv - scoreboard bench for fft_radix2_stream at N=8 and N=16
module tb_fft_radix2_stream;
    typedef struct { int re; int im; bit last; int tol; } exp_t;

    logic clk = 1'b0;
    logic clear = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
    logic        in_ready8, out_valid8, out_last8, busy8;
    logic [7:0]  in_re8 = '0, in_im8 = '0;
    logic [11:0] out_re8, out_im8;

    logic        in_valid16 = 1'b0, out_ready16 = 1'b1;
    logic        in_ready16, out_valid16, out_last16, busy16;
    logic [7:0]  in_re16 = '0, in_im16 = '0;
    logic [12:0] out_re16, out_im16;

    int checks = 0, fails = 0, cyc = 0;
    exp_t q8[$], q16[$];

    int k2_in[8] = '{4, 1, 2, -3, 1, -2, 0, 3};
    int k2_re[8] = '{6, 9, 3, -3, 8, -3, 3, 9};
    int k2_im[8] = '{0, 0, 1, 4, 0, -4, -1, 0};

    fft_radix2_stream #(.N(8), .LOG2N(3), .DW(8)) dut8 (
        .clk(clk), .clear(clear), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_re(in_re8), .in_im(in_im8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_re(out_re8), .out_im(out_im8), .out_last(out_last8), .busy(busy8)
    );

    fft_radix2_stream #(.N(16), .LOG2N(4), .DW(8)) dut16 (
        .clk(clk), .clear(clear), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_re(in_re16), .in_im(in_im16), .out_valid(out_valid16), .out_ready(out_ready16),
        .out_re(out_re16), .out_im(out_im16), .out_last(out_last16), .busy(busy16)
    );

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp, input int tol = 0);
        int d;
        checks++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
        end
    endtask

    task automatic send8(input int re, input int im, input int gap);
        int t = 0;
        in_re8 = 8'(re);
        in_im8 = 8'(im);
        in_valid8 = 1'b1;
        @(negedge clk);
        while (!in_ready8 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) chk("send8_ready_timeout", int'(in_ready8), 1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send16(input int re, input int im);
        int t = 0;
        in_re16 = 8'(re);
        in_im16 = 8'(im);
        in_valid16 = 1'b1;
        @(negedge clk);
        while (!in_ready16 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) chk("send16_ready_timeout", int'(in_ready16), 1);
        @(posedge clk); #1;
        in_valid16 = 1'b0;
    endtask

    task automatic drain8(input int budget);
        int t = 0;
        while ((q8.size() != 0 || out_valid8) && t < budget) begin @(posedge clk); #1; t++; end
        if (t >= budget) chk("drain8_timeout", int'(out_valid8) + q8.size(), 0);
    endtask

    task automatic drain16(input int budget);
        int t = 0;
        while ((q16.size() != 0 || out_valid16) && t < budget) begin @(posedge clk); #1; t++; end
        if (t >= budget) chk("drain16_timeout", int'(out_valid16) + q16.size(), 0);
    endtask

    // Output-side model for the 8-point instance: busy window, latency, stall stability
    int   last_acc8 = 0, acc8 = 0, bin8 = 0;
    bit   exp_busy8 = 1'b0, ov_prev8 = 1'b0, stall_prev8 = 1'b0, mon_on = 1'b0;
    logic [11:0] pre_re8 = '0, pre_im8 = '0;
    logic pre_last8 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        bit nb;
        if (mon_on) begin
            chk("busy8", int'(busy8), int'(exp_busy8));
            chk("in_ready8", int'(in_ready8), int'(!exp_busy8));
            if (stall_prev8 && !clear) begin
                chk("stall_valid8", int'(out_valid8), 1);
                chk("stall_re8", int'($signed(out_re8)), int'($signed(pre_re8)));
                chk("stall_im8", int'($signed(out_im8)), int'($signed(pre_im8)));
                chk("stall_last8", int'(out_last8), int'(pre_last8));
            end
            if (out_valid8 && !ov_prev8) chk("latency8", cyc - last_acc8, 13);
            if (out_valid8 && out_ready8 && !clear) begin
                if (q8.size() == 0) chk("unexpected_bin8", int'(out_valid8), 0);
                else begin
                    e = q8.pop_front();
                    chk($sformatf("bin8[%0d].re", bin8), int'($signed(out_re8)), e.re, e.tol);
                    chk($sformatf("bin8[%0d].im", bin8), int'($signed(out_im8)), e.im, e.tol);
                    chk($sformatf("bin8[%0d].last", bin8), int'(out_last8), int'(e.last));
                end
            end
            if (in_valid8 && in_ready8) last_acc8 = cyc;
            nb = exp_busy8;
            if (clear) begin
                nb = 1'b0; acc8 = 0; bin8 = 0;
            end else begin
                if (in_valid8 && in_ready8) begin
                    acc8++;
                    if (acc8 == 8) begin nb = 1'b1; acc8 = 0; end
                end
                if (out_valid8 && out_ready8) begin
                    if (bin8 == 7) begin nb = 1'b0; bin8 = 0; end
                    else bin8++;
                end
            end
            exp_busy8 = nb;
        end
        ov_prev8    = out_valid8;
        stall_prev8 = out_valid8 && !out_ready8;
        pre_re8     = out_re8;
        pre_im8     = out_im8;
        pre_last8   = out_last8;
    end

    int last_acc16 = 0, bin16 = 0;
    bit ov_prev16 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (out_valid16 && !ov_prev16) chk("latency16", cyc - last_acc16, 33);
            if (out_valid16 && out_ready16 && !clear) begin
                if (q16.size() == 0) chk("unexpected_bin16", int'(out_valid16), 0);
                else begin
                    e = q16.pop_front();
                    chk($sformatf("bin16[%0d].re", bin16), int'($signed(out_re16)), e.re, e.tol);
                    chk($sformatf("bin16[%0d].im", bin16), int'($signed(out_im16)), e.im, e.tol);
                    chk($sformatf("bin16[%0d].last", bin16), int'(out_last16), int'(e.last));
                end
                bin16 = (bin16 + 1) % 16;
            end
            if (in_valid16 && in_ready16) last_acc16 = cyc;
        end
        ov_prev16 = out_valid16;
    end

    // Holds out_ready low for three cycles while bins 2 and 7 are presented
    bit stall_en = 1'b0;
    int stall_cnt = 0, stall_bin = -1;

    always @(posedge clk) begin
        #1;
        if (bin8 != stall_bin) begin stall_bin = bin8; stall_cnt = 0; end
        if (stall_en && out_valid8 && (bin8 == 2 || bin8 == 7) && stall_cnt < 3) begin
            out_ready8 = 1'b0;
            stall_cnt++;
        end else begin
            out_ready8 = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        mon_on = 1'b1;
        clear = 1'b0;
        @(negedge clk);
        chk("reset_out_valid8", int'(out_valid8), 0);
        chk("reset_in_ready8", int'(in_ready8), 1);
        chk("reset_busy8", int'(busy8), 0);
        chk("reset_out_re8", int'(out_re8), 0);
        chk("reset_out_im8", int'(out_im8), 0);
        chk("reset_out_last8", int'(out_last8), 0);
        chk("reset_in_ready16", int'(in_ready16), 1);
        chk("reset_busy16", int'(busy16), 0);
        @(posedge clk); #1;

        // Impulse
        for (int i = 0; i < 8; i++) q8.push_back('{64, 0, i == 7, 0});
        for (int i = 0; i < 8; i++) send8(i == 0 ? 64 : 0, 0, 0);
        drain8(200);

        // Known vector
        for (int i = 0; i < 8; i++) q8.push_back('{k2_re[i], k2_im[i], i == 7, i % 2});
        for (int i = 0; i < 8; i++) send8(k2_in[i], 0, 0);
        drain8(200);

        // Full-scale negative
        for (int i = 0; i < 8; i++) q8.push_back('{i == 0 ? -1024 : 0, i == 0 ? -1024 : 0, i == 7, 0});
        for (int i = 0; i < 8; i++) send8(-128, -128, 0);
        drain8(200);

        // Gapped input and stalled output
        stall_en = 1'b1;
        for (int i = 0; i < 8; i++) q8.push_back('{k2_re[i], k2_im[i], i == 7, i % 2});
        for (int i = 0; i < 8; i++) send8(k2_in[i], 0, 1);
        drain8(300);
        stall_en = 1'b0;

        // Clear during COMPUTE cycle 5 aborts the frame
        for (int i = 0; i < 8; i++) send8(i == 0 ? 64 : 0, 0, 0);
        repeat (4) begin @(posedge clk); #1; end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("abort_out_valid8", int'(out_valid8), 0);
        chk("abort_in_ready8", int'(in_ready8), 1);
        chk("abort_busy8", int'(busy8), 0);
        repeat (20) @(negedge clk);
        chk("abort_no_output8", int'(out_valid8), 0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) q8.push_back('{64, 0, i == 7, 0});
        for (int i = 0; i < 8; i++) send8(i == 0 ? 64 : 0, 0, 0);
        drain8(200);

        // N=16: DC frame then back-to-back impulse frame
        for (int i = 0; i < 16; i++) q16.push_back('{i == 0 ? 160 : 0, 0, i == 15, 0});
        for (int i = 0; i < 16; i++) q16.push_back('{64, 0, i == 15, 0});
        for (int i = 0; i < 16; i++) send16(10, 0);
        for (int i = 0; i < 16; i++) send16(i == 0 ? 64 : 0, 0);
        drain16(300);

        repeat (3) @(negedge clk);
        chk("q8_empty", q8.size(), 0);
        chk("q16_empty", q16.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
